instruction_buffer: RTL and testbench

Two-wide instruction FIFO that sits between the instruction fetcher and decode. Accepts up to two `{instruction, address}` pairs per cycle from the fetcher and presents the two oldest entries to decode, which may consume zero, one or two per cycle. Back-pressures the fetcher through `stall` and discards all contents on a branch flush.

---
 rtl/instruction_buffer.sv | 157 +++++++++++++++
 tb/tb_instruction_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instruction_buffer.sv
// ============================================================================
// Module   : instruction_buffer
// Summary  : Two-wide instruction FIFO between fetch and decode. Up to two
//            {instruction, address} pairs enter per cycle. The two oldest
//            entries are shown to decode, which may take zero, one or two of
//            them per cycle. A branch flush empties the buffer.
// Options  : IBUF_BYPASS_EN - when defined, incoming entries pass through
//            combinationally to an empty output slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] instructionA,
  input  logic [31:0] instructionB,
  input  logic [31:0] addressA,
  input  logic [31:0] addressB,
  input  logic        instructionA_valid,
  input  logic        instructionB_valid,
  output logic        stall,
  output logic [31:0] outInstructionA,
  output logic [31:0] outInstructionB,
  output logic [31:0] outAddressA,
  output logic [31:0] outAddressB,
  output logic        outA_valid,
  output logic        outB_valid,
  input  logic        dequeueA,
  input  logic        dequeueB
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each entry is {address, instruction}
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [63:0]   in_a;
  logic [63:0]   in_b;
  logic [63:0]   slot_a;
  logic [63:0]   slot_b;
  logic          slot_a_v;
  logic          slot_b_v;
  logic [1:0]    deq;
  logic [1:0]    n_wr;
  logic [CW:0]   space;
  logic          wr_a;
  logic          wr_b;
  logic          write_a;
  logic          write_b;

  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;
  assign in_a    = {addressA, instructionA};
  assign in_b    = {addressB, instructionB};

`ifdef IBUF_BYPASS_EN
  logic [1:0] bc;

  // Output slots come from storage, or straight from the fetcher when the
  // matching stored entry is absent and no flush is in progress
  always_comb begin
    slot_a   = mem[head];
    slot_b   = mem[head_p1];
    slot_a_v = (count != '0);
    slot_b_v = (count >= CW'(2));
    if (!flush && count == '0) begin
      slot_a   = in_a;
      slot_a_v = instructionA_valid;
      slot_b   = in_b;
      slot_b_v = instructionA_valid & instructionB_valid;
    end else if (!flush && count == CW'(1)) begin
      slot_b   = in_a;
      slot_b_v = instructionA_valid;
    end
  end

  // Incoming entries consumed through the bypass are never stored; the
  // first 'bc' of the incoming pair are the ones decode took this cycle
  always_comb begin
    bc = 2'd0;
    if (CW'(deq) > count) bc = deq - count[1:0];
    write_a = wr_a & ~flush & (bc == 2'd0);
    write_b = wr_b & ~flush & (bc != 2'd2);
  end
`else
  // Output slots always come from storage; no input-to-output path
  always_comb begin
    slot_a   = mem[head];
    slot_b   = mem[head_p1];
    slot_a_v = (count != '0);
    slot_b_v = (count >= CW'(2));
  end

  // Every accepted entry is stored
  always_comb begin
    write_a = wr_a & ~flush;
    write_b = wr_b & ~flush;
  end
`endif

  // Dequeue/enqueue amounts; room freed by this cycle's dequeue is usable,
  // and any excess beyond free space is dropped B first, then A
  always_comb begin
    deq   = {1'b0, dequeueA & slot_a_v} + {1'b0, dequeueA & dequeueB & slot_b_v};
    space = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(deq);
    wr_a  = instructionA_valid && (space >= (CW+1)'(1));
    wr_b  = instructionA_valid && instructionB_valid && (space >= (CW+1)'(2));
    n_wr  = {1'b0, wr_a} + {1'b0, wr_b};
  end

  // Pointer and occupancy update; flush overrides all traffic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq);
      tail  <= tail + AW'(n_wr);
      count <= count + CW'(n_wr) - CW'(deq);
    end
  end

  // Storage writes; contents are left untouched by reset and flush
  always_ff @(posedge clk) begin
    if (write_a) mem[tail]    <= in_a;
    if (write_b) mem[tail_p1] <= in_b;
  end

  // Output gating: data reads as zero whenever its slot is empty
  always_comb begin
    outA_valid      = slot_a_v;
    outB_valid      = slot_b_v;
    outInstructionA = slot_a_v ? slot_a[31:0]  : '0;
    outAddressA     = slot_a_v ? slot_a[63:32] : '0;
    outInstructionB = slot_b_v ? slot_b[31:0]  : '0;
    outAddressB     = slot_b_v ? slot_b[63:32] : '0;
    stall           = (count > CW'(DEPTH - 2));
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_buffer.sv
// ============================================================================
// Module   : tb_instruction_buffer
// Summary  : Directed, self-checking bench for instruction_buffer (DEPTH=8,
//            default build). A queue holds the expected FIFO contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instructionA = '0, instructionB = '0;
  logic [31:0] addressA = '0, addressB = '0;
  logic        instructionA_valid = 1'b0, instructionB_valid = 1'b0;
  logic        dequeueA = 1'b0, dequeueB = 1'b0;
  logic        stall;
  logic [31:0] outInstructionA, outInstructionB, outAddressA, outAddressB;
  logic        outA_valid, outB_valid;

  int total = 0;
  int bad   = 0;
  logic [63:0] q[$];

  instruction_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .instructionA(instructionA), .instructionB(instructionB),
    .addressA(addressA), .addressB(addressB),
    .instructionA_valid(instructionA_valid), .instructionB_valid(instructionB_valid),
    .stall(stall),
    .outInstructionA(outInstructionA), .outInstructionB(outInstructionB),
    .outAddressA(outAddressA), .outAddressB(outAddressB),
    .outA_valid(outA_valid), .outB_valid(outB_valid),
    .dequeueA(dequeueA), .dequeueB(dequeueB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the output slots against the model, apply one clock of traffic,
  // then check occupancy and stall against the model
  task automatic cyc(input bit av, input logic [31:0] ia, input logic [31:0] aa,
                     input bit bv, input logic [31:0] ib, input logic [31:0] ab,
                     input bit da, input bit db, input bit fl);
    int n;
    instructionA = ia; addressA = aa; instructionA_valid = av;
    instructionB = ib; addressB = ab; instructionB_valid = bv;
    dequeueA = da; dequeueB = db; flush = fl;
    n = q.size();
    chk("a_valid", 64'(outA_valid), 64'(n >= 1));
    chk("b_valid", 64'(outB_valid), 64'(n >= 2));
    chk("slot_a", {outAddressA, outInstructionA}, (n >= 1) ? q[0] : 64'd0);
    chk("slot_b", {outAddressB, outInstructionB}, (n >= 2) ? q[1] : 64'd0);
    if (fl) begin
      q.delete();
    end else begin
      if (da && n >= 1) void'(q.pop_front());
      if (da && db && n >= 2) void'(q.pop_front());
      if (av && q.size() < DEPTH) q.push_back({aa, ia});
      if (av && bv && q.size() < DEPTH) q.push_back({ab, ib});
    end
    @(posedge clk);
    #1;
    instructionA_valid = 1'b0; instructionB_valid = 1'b0;
    dequeueA = 1'b0; dequeueB = 1'b0; flush = 1'b0;
    chk("count", 64'(dut.count), 64'(q.size()));
    chk("stall", 64'(stall), 64'(q.size() > DEPTH - 2));
  endtask

  task automatic enq_pair(input logic [31:0] a);
    cyc(1'b1, 32'h13 + a * 32'h20, a, 1'b1, 32'h93 + a * 32'h20, a + 32'd4,
        1'b0, 1'b0, 1'b0);
  endtask

  task automatic deq_pair();
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_count", 64'(dut.count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_valids", {62'd0, outA_valid, outB_valid}, 64'd0);
    chk("rst_data", {outInstructionA, outAddressB}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill with four pairs, no dequeue
    enq_pair(32'h0);
    enq_pair(32'h8);
    enq_pair(32'h10);
    chk("fill3_count", 64'(dut.count), 64'd6);
    chk("fill3_stall", 64'(stall), 64'd0);
    enq_pair(32'h18);
    chk("fill4_count", 64'(dut.count), 64'd8);
    chk("fill4_stall", 64'(stall), 64'd1);

    // Full: dequeue two and enqueue two in the same cycle
    cyc(1'b1, 32'hC0DE0001, 32'h40, 1'b1, 32'hC0DE0002, 32'h44, 1'b1, 1'b1, 1'b0);
    chk("full_swap_count", 64'(dut.count), 64'd8);

    // Drain in order
    repeat (4) deq_pair();

    // Single-wide enqueue into an empty buffer
    cyc(1'b1, 32'hAAAA0001, 32'h104, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("single_addr", 64'(outAddressA), 64'h104);
    chk("single_instrB", 64'(outInstructionB), 64'd0);
    // dequeueB alone is ignored
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Move head/tail up to 7, then enqueue a pair straddling the wrap
    enq_pair(32'h100);
    enq_pair(32'h108);
    deq_pair();
    deq_pair();
    chk("wrap_head", 64'(dut.head), 64'd7);
    cyc(1'b1, 32'h1200, 32'h200, 1'b1, 32'h1204, 32'h204, 1'b0, 1'b0, 1'b0);
    chk("wrap_mem7", dut.mem[7], {32'h200, 32'h1200});
    chk("wrap_mem0", dut.mem[0], {32'h204, 32'h1204});
    deq_pair();
    chk("wrap_empty", 64'(dut.count), 64'd0);

    // Flush colliding with enqueue and dequeue at count 5
    enq_pair(32'h300);
    enq_pair(32'h308);
    cyc(1'b1, 32'h5555, 32'h310, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(dut.count), 64'd5);
    cyc(1'b1, 32'h6666, 32'h400, 1'b1, 32'h7777, 32'h404, 1'b1, 1'b1, 1'b1);
    chk("flush_valids", {62'd0, outA_valid, outB_valid}, 64'd0);
    cyc(1'b1, 32'h8888, 32'h500, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_flush_slotA", {outAddressA, outInstructionA}, {32'h500, 32'h8888});
    deq_pair();

    // Asynchronous reset mid-cycle with count 6
    enq_pair(32'h600);
    enq_pair(32'h608);
    enq_pair(32'h610);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    chk("arst_valids", {62'd0, outA_valid, outB_valid}, 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_count", 64'(dut.count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    enq_pair(32'h700);
    deq_pair();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
